// File: rtl/bpred_btb.sv
// bpred_btb: direct-mapped branch target buffer with 2-bit direction counters.
//
// Ports:
//   CLK, RESET           clock; asynchronous active-high reset
//   Fetch_PC/_Valid/_Stall  IF lookup; prediction is combinational this cycle
//   Pred_Taken/Pred_Target  predicted direction and next PC for IF
//   Resolve_*            branch outcome from ID plus what was predicted at fetch
//   Invalidate           synchronous clear of all entries and the pending update
//   Lookup_Count         saturating count of unstalled valid fetches
//   Mispredict_Count     saturating count of mispredicted resolutions
//
// A resolution is captured into a one-entry pending register and written to
// the table one edge later. The pending entry already holds the post-update
// value, so both the lookup and the next resolution simply bypass it when the
// index matches.
module bpred_btb #(
  parameter int         IDX_W    = 4,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Fetch_PC,
  input  logic        Fetch_Valid,
  input  logic        Fetch_Stall,
  output logic        Pred_Taken,
  output logic [31:0] Pred_Target,
  input  logic        Resolve_Valid,
  input  logic [31:0] Resolve_PC,
  input  logic        Resolve_Taken,
  input  logic [31:0] Resolve_Target,
  input  logic        Resolve_Pred_Taken,
  input  logic [31:0] Resolve_Pred_Target,
  input  logic        Invalidate,
  output logic [31:0] Lookup_Count,
  output logic [31:0] Mispredict_Count
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  function automatic logic [1:0] sat_inc2(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] sat_dec2(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  function automatic logic [31:0] sat_inc32(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic             tbl_valid  [ENTRIES];
  logic [TAG_W-1:0] tbl_tag    [ENTRIES];
  logic [31:0]      tbl_target [ENTRIES];
  logic [1:0]       tbl_cnt    [ENTRIES];

  logic             pend_vld_p1;
  logic [IDX_W-1:0] pend_idx_p1;
  logic             pend_valid_p1;
  logic [TAG_W-1:0] pend_tag_p1;
  logic [31:0]      pend_target_p1;
  logic [1:0]       pend_cnt_p1;

  logic [31:0]      lookup_cnt;
  logic [31:0]      mispred_cnt;

  logic [IDX_W-1:0] fetch_idx, res_idx;
  logic [TAG_W-1:0] fetch_tag, res_tag;
  logic             unused_pc_bits;

  assign fetch_idx      = Fetch_PC[IDX_W+1:2];
  assign fetch_tag      = Fetch_PC[31:IDX_W+2];
  assign res_idx        = Resolve_PC[IDX_W+1:2];
  assign res_tag        = Resolve_PC[31:IDX_W+2];
  assign unused_pc_bits = ^Resolve_PC[1:0];

  // ---- stage p0: lookup (table view including pending write) ----
  logic             lk_valid;
  logic [TAG_W-1:0] lk_tag;
  logic [31:0]      lk_target;
  logic [1:0]       lk_cnt;
  logic             lk_hit;

  always_comb begin
    lk_valid  = tbl_valid[fetch_idx];
    lk_tag    = tbl_tag[fetch_idx];
    lk_target = tbl_target[fetch_idx];
    lk_cnt    = tbl_cnt[fetch_idx];
    if (pend_vld_p1 && (pend_idx_p1 == fetch_idx)) begin
      lk_valid  = pend_valid_p1;
      lk_tag    = pend_tag_p1;
      lk_target = pend_target_p1;
      lk_cnt    = pend_cnt_p1;
    end
  end

  assign lk_hit      = lk_valid && (lk_tag == fetch_tag);
  // The RESET term keeps the output defined even before the async clear settles.
  assign Pred_Taken  = lk_hit && lk_cnt[1] && !RESET;
  assign Pred_Target = Pred_Taken ? lk_target : Fetch_PC + 32'd4;

  // ---- stage p0: resolution -> post-update entry value ----
  logic             rs_valid;
  logic [TAG_W-1:0] rs_tag;
  logic [31:0]      rs_target;
  logic [1:0]       rs_cnt;
  logic             rs_hit;
  logic             nx_valid;
  logic [TAG_W-1:0] nx_tag;
  logic [31:0]      nx_target;
  logic [1:0]       nx_cnt;
  logic             mispredict;

  always_comb begin
    rs_valid  = tbl_valid[res_idx];
    rs_tag    = tbl_tag[res_idx];
    rs_target = tbl_target[res_idx];
    rs_cnt    = tbl_cnt[res_idx];
    // An older update to the same index is still pending; judge against it.
    if (pend_vld_p1 && (pend_idx_p1 == res_idx)) begin
      rs_valid  = pend_valid_p1;
      rs_tag    = pend_tag_p1;
      rs_target = pend_target_p1;
      rs_cnt    = pend_cnt_p1;
    end
    rs_hit    = rs_valid && (rs_tag == res_tag);
    nx_valid  = rs_valid;
    nx_tag    = rs_tag;
    nx_target = rs_target;
    nx_cnt    = rs_cnt;
    if (rs_hit) begin
      if (Resolve_Taken) begin
        nx_cnt    = sat_inc2(rs_cnt);
        nx_target = Resolve_Target;
      end else begin
        nx_cnt    = sat_dec2(rs_cnt);
      end
    end else if (Resolve_Taken) begin
      nx_valid  = 1'b1;
      nx_tag    = res_tag;
      nx_target = Resolve_Target;
      nx_cnt    = 2'b10;
    end
  end

  assign mispredict = (Resolve_Pred_Taken != Resolve_Taken) ||
                      (Resolve_Taken && Resolve_Pred_Taken &&
                       (Resolve_Pred_Target != Resolve_Target));

  // ---- stage p1: pending register, table write, statistics ----
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tbl_valid[i]  <= 1'b0;
        tbl_tag[i]    <= '0;
        tbl_target[i] <= '0;
        tbl_cnt[i]    <= CNT_INIT;
      end
      pend_vld_p1 <= 1'b0;
      lookup_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (Fetch_Valid && !Fetch_Stall)
        lookup_cnt <= sat_inc32(lookup_cnt);
      if (Resolve_Valid && mispredict)
        mispred_cnt <= sat_inc32(mispred_cnt);
      if (Invalidate) begin
        for (int i = 0; i < ENTRIES; i++) begin
          tbl_valid[i] <= 1'b0;
          tbl_cnt[i]   <= CNT_INIT;
        end
        pend_vld_p1 <= 1'b0;
      end else begin
        if (pend_vld_p1) begin
          tbl_valid[pend_idx_p1]  <= pend_valid_p1;
          tbl_tag[pend_idx_p1]    <= pend_tag_p1;
          tbl_target[pend_idx_p1] <= pend_target_p1;
          tbl_cnt[pend_idx_p1]    <= pend_cnt_p1;
        end
        pend_vld_p1 <= Resolve_Valid;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Resolve_Valid) begin
      pend_idx_p1    <= res_idx;
      pend_valid_p1  <= nx_valid;
      pend_tag_p1    <= nx_tag;
      pend_target_p1 <= nx_target;
      pend_cnt_p1    <= nx_cnt;
    end
  end

  assign Lookup_Count     = lookup_cnt;
  assign Mispredict_Count = mispred_cnt;
endmodule
